// File: rtl/dac_frame_rx_pkg.sv
// Shared definitions for the DAC serial frame receiver: receiver state
// encoding and the default frame / synchronizer geometry.
package dac_frame_rx_pkg;

   localparam int DEF_WORD_W      = 16;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_ERR  = 2'd2
   } rx_state_e;

endpackage

// File: rtl/dac_frame_rx_if.sv
// Word-side bus of the DAC frame receiver: committed word, valid/ready
// handshake and the two status pulses.
interface dac_frame_rx_if
   import dac_frame_rx_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) ();

   logic [WORD_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              frame_err;
   logic              overrun;

   modport master (
      output data_out,
      output data_valid,
      output frame_err,
      output overrun,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  overrun,
      output data_ready
   );

endinterface

// File: rtl/dac_frame_rx_sig_sync_edge.sv
// Synchronizer chain for one asynchronous line, followed by a delay flop
// that turns level changes of the synchronized signal into one-cycle
// rise/fall pulses. Reset loads the idle level of the line.
module sig_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_r;
   logic              dly_r;

   // Shift the raw line through the synchronizer, then keep one older copy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain_r <= {STAGES{RST_VAL}};
         dly_r   <= RST_VAL;
      end else begin
         chain_r <= {chain_r[STAGES-2:0], async_in};
         dly_r   <= chain_r[STAGES-1];
      end
   end

   assign sync_out = chain_r[STAGES-1];
   assign rise     = chain_r[STAGES-1] & ~dly_r;
   assign fall     = ~chain_r[STAGES-1] & dly_r;

endmodule

// File: rtl/dac_frame_rx.sv
// Receiver for DAC-style serial frames (SYNC low framing, data sampled on
// SCLK falling edges, MSB first). Good frames are committed into a single
// output word register with a valid/ready handshake; malformed frames and
// overwritten words are reported as one-cycle pulses.
module dac_frame_rx
   import dac_frame_rx_pkg::*;
#(
   parameter int WORD_W      = DEF_WORD_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sclk_in,
   input  logic            sync_in,
   input  logic            din_in,
   dac_frame_rx_if.master  rx_if
);

   localparam int             CNT_W    = $clog2(WORD_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(WORD_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
   logic sync_lvl_s, sync_rise_s, sync_fall_s;
   logic din_lvl_s,  din_rise_s,  din_fall_s;
   logic unused_s;

   rx_state_e         state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [WORD_W-1:0] shreg_r;
   logic [WORD_W-1:0] data_r;
   logic              valid_r;
   logic              ferr_r;
   logic              ovr_r;
   logic              commit_s;
   logic              bit_take_s;

   sig_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (sclk_in),
      .sync_out (sclk_lvl_s),
      .rise     (sclk_rise_s),
      .fall     (sclk_fall_s)
   );

   sig_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (sync_in),
      .sync_out (sync_lvl_s),
      .rise     (sync_rise_s),
      .fall     (sync_fall_s)
   );

   sig_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_din_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (din_in),
      .sync_out (din_lvl_s),
      .rise     (din_rise_s),
      .fall     (din_fall_s)
   );

   // Edge pulses of SCLK rise and DIN are not needed; only levels/falls are.
   assign unused_s = &{1'b1, sclk_lvl_s, sclk_rise_s, din_rise_s, din_fall_s};

   // Decide whether this cycle takes a bit or ends a full-length frame.
   always_comb begin
      commit_s   = 1'b0;
      bit_take_s = 1'b0;
      if ((state_r == ST_RECV) && sync_rise_s && (cnt_r == CNT_FULL)) begin
         commit_s = 1'b1;
      end else begin
         commit_s = 1'b0;
      end
      // A SYNC rise in the same cycle wins over an SCLK fall.
      if (sclk_fall_s && !sync_lvl_s && !sync_rise_s) begin
         bit_take_s = 1'b1;
      end else begin
         bit_take_s = 1'b0;
      end
   end

   // Frame FSM, shift register, output word and status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         shreg_r <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         ovr_r   <= 1'b0;
      end else begin
         ferr_r <= 1'b0;
         ovr_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (sync_fall_s) begin
                  state_r <= ST_RECV;
                  cnt_r   <= '0;
                  shreg_r <= '0;
               end
            end
            ST_RECV: begin
               if (sync_rise_s) begin
                  state_r <= ST_IDLE;
                  if (cnt_r != CNT_FULL) begin
                     ferr_r <= 1'b1;
                  end
               end else if (bit_take_s) begin
                  shreg_r <= {shreg_r[WORD_W-2:0], din_lvl_s};
                  if (cnt_r != CNT_OVER) begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
                  // This falling edge is one bit too many.
                  if (cnt_r == CNT_FULL) begin
                     state_r <= ST_ERR;
                     ferr_r  <= 1'b1;
                  end
               end
            end
            ST_ERR: begin
               if (sync_rise_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase

         if (commit_s) begin
            data_r  <= shreg_r;
            valid_r <= 1'b1;
            ovr_r   <= valid_r && !rx_if.data_ready;
         end else if (valid_r && rx_if.data_ready) begin
            valid_r <= 1'b0;
         end
      end
   end

   assign rx_if.data_out   = data_r;
   assign rx_if.data_valid = valid_r;
   assign rx_if.frame_err  = ferr_r;
   assign rx_if.overrun    = ovr_r;

endmodule

// File: doc/dac_frame_rx.md
DAC_FRAME_RX -- requirements
Module: dac_frame_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 16, giving the frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on each serial input; legal values 2..4.
REQ-003 clk  input  1  system clock; all logic runs on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 sclk_in  input  1  serial clock from the DAC-side transmitter; asynchronous to clk.
REQ-006 sync_in  input  1  frame strobe, active-low; asynchronous to clk.
REQ-007 din_in  input  1  serial data, MSB first; asynchronous to clk.
REQ-008 data_out  output  WORD_W  last committed word.
REQ-009 data_valid  output  1  data_out holds an unconsumed word.
REQ-010 data_ready  input  1  consumer accepts data_out when it is high in the same cycle as data_valid.
REQ-011 frame_err  output  1  one-cycle pulse when a malformed frame is discarded.
REQ-012 overrun  output  1  one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-013 SHALL pass sclk_in, sync_in and din_in through SYNC_STAGES flops, then one delay flop for edge detection; all decisions use only the synchronized signals.
REQ-014 SHALL sample the synchronized din on each detected sclk falling edge while the synchronized sync is low, and shift it in MSB first.
REQ-015 FSM states: IDLE, RECV, ERR.
REQ-016 IDLE -> RECV on a sync falling edge; this clears the bit counter and shift register.
REQ-017 RECV: each sclk falling edge increments the bit counter, which saturates at WORD_W+1.
REQ-018 RECV -> IDLE on a sync rising edge. If the count equals WORD_W, the word SHALL be committed; otherwise frame_err SHALL pulse and the word SHALL be discarded.
REQ-019 RECV -> ERR on the (WORD_W+1)th falling edge; frame_err SHALL pulse in that cycle.
REQ-020 ERR -> IDLE on a sync rising edge; no commit and no second frame_err.
REQ-021 If an sclk falling edge and a sync rising edge are detected in the same cycle, the sync edge SHALL win and the bit SHALL NOT be counted.
REQ-022 Commit: data_out loads the word and data_valid is set. data_valid is visible exactly SYNC_STAGES+1 clk edges after the first edge that samples sync_in high.
REQ-023 data_valid SHALL clear on the cycle after a handshake (data_valid && data_ready) when no commit occurs in the same cycle.
REQ-024 If a commit coincides with a handshake, the new word SHALL load and data_valid SHALL stay high; overrun SHALL NOT pulse.
REQ-025 If a commit occurs while data_valid is high and data_ready is low, data_out SHALL be replaced and overrun SHALL pulse for one cycle.
REQ-026 Correct capture requires sclk_in high and low phases each of at least SYNC_STAGES+1 clk periods; faster SCLK is out of scope.
REQ-027 A sync falling edge seen in RECV or ERR SHALL NOT restart the frame; only a return to IDLE re-arms the receiver.

Reset
REQ-028 While rst_n is low at a clk edge: state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, overrun=0, and all synchronizer flops=1 (idle-high lines).
REQ-029 Reset mid-frame SHALL discard the partial frame without a frame_err pulse. The first frame whose sync falling edge is detected after release SHALL be received normally.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE/RECV/ERR) and the default WORD_W and SYNC_STAGES constants.
REQ-031 One sub-module, sig_sync_edge, SHALL be instantiated once per serial input. It provides the synchronizer chain plus rise and fall pulses, parameterized by SYNC_STAGES and reset value.

Verification
REQ-032 16-bit frame 0x8C8B, clk/sclk ratio 12, data_ready=1 -> data_out=0x8C8B, data_valid high for 1 cycle, exactly 3 clk edges after sync_in is sampled high; frame_err=0.
REQ-033 15-bit frame, then a 17-bit frame -> frame_err pulses once for each frame (on the sync rise for the first, on the 17th falling edge for the second); data_valid never asserts.
REQ-034 Frames 0x1234 then 0xABCD with data_ready=0 -> overrun pulses once at the second commit; data_out=0xABCD; data_valid stays high until data_ready=1 for one cycle.
REQ-035 rst_n low for 2 cycles after bit 8 of a frame -> all outputs 0, no frame_err; the following frame 0xFFFF is received correctly.
REQ-036 16 bits sent, then a 17th sclk falling edge forced into the same clk cycle as the sync rise -> the frame is committed with the 16-bit value and frame_err=0.
